// File: rtl/bus_sequencer_if.sv
// -----------------------------------------------------------------------------
// bus_sequencer_if
// Bundle of the handshake and control signals exchanged between the control-step
// sequencer and the shared-bus datapath.
//   start      : one-cycle request to run one instruction
//   ir         : instruction register contents (opcode ir[31:27], ra/rb/rc below)
//   mem_ready  : memory read complete
//   reg_out    : one-hot register bus-source enables (bit n = Rnout)
//   reg_in     : one-hot register load enables
//   HIout..Cout: remaining bus-source enables
//   PCin..LOin : load and control strobes
//   alu_op     : ALU operation code
//   busy/done/illegal : sequencer status
// Modports:
//   master : the sequencer (drives enables, receives start/ir/mem_ready)
//   slave  : the datapath/top level (mirror image)
// -----------------------------------------------------------------------------
interface bus_sequencer_if;
    logic        start;
    logic [31:0] ir;
    logic        mem_ready;

    logic [15:0] reg_out;
    logic [15:0] reg_in;

    logic        HIout;
    logic        LOout;
    logic        Zhighout;
    logic        Zlowout;
    logic        PCout;
    logic        MDRout;
    logic        InPortout;
    logic        Cout;

    logic        PCin;
    logic        IncPC;
    logic        MARin;
    logic        MDRin;
    logic        Read;
    logic        IRin;
    logic        Yin;
    logic        Zin;
    logic        HIin;
    logic        LOin;

    logic [4:0]  alu_op;
    logic        busy;
    logic        done;
    logic        illegal;

    modport master (
        input  start, ir, mem_ready,
        output reg_out, reg_in,
        output HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout,
        output PCin, IncPC, MARin, MDRin, Read, IRin, Yin, Zin, HIin, LOin,
        output alu_op, busy, done, illegal
    );

    modport slave (
        output start, ir, mem_ready,
        input  reg_out, reg_in,
        input  HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout,
        input  PCin, IncPC, MARin, MDRin, Read, IRin, Yin, Zin, HIin, LOin,
        input  alu_op, busy, done, illegal
    );
endinterface

// File: rtl/bus_sequencer.sv
// -----------------------------------------------------------------------------
// bus_sequencer
// Multi-cycle control-step sequencer for a single shared 32-bit datapath bus.
// One instruction is stepped through fetch (T0-T2) and execute (T3-T6), then a
// FIN step reports completion. All bus enables and strobes are Moore outputs
// decoded from the registered state and ir.
// Ports:
//   clock : rising-edge clock
//   clear : asynchronous active-high reset (aborts any instruction at once)
//   bus   : bus_sequencer_if.master (start, ir, mem_ready in; enables out)
// Parameters:
//   OPW : opcode width (ir[31:27])
//   RAW : register-field width (ra=ir[26:23], rb=ir[22:19], rc=ir[18:15])
// -----------------------------------------------------------------------------
module bus_sequencer #(
    parameter int OPW = 5,
    parameter int RAW = 4
) (
    input  logic             clock,
    input  logic             clear,
    bus_sequencer_if.master  bus
);

    localparam int NREG = 2 ** RAW;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        T6   = 4'd7,
        FIN  = 4'd8
    } state_t;

    state_t           state_r;
    state_t           next_s;
    logic             illegal_r;
    logic             illegal_next_s;

    logic [OPW-1:0]   opcode_s;
    logic [RAW-1:0]   ra_s;
    logic [RAW-1:0]   rb_s;
    logic [RAW-1:0]   rc_s;

    // One-hot decode of a register field into the Rn enable vector.
    function automatic logic [NREG-1:0] reg_onehot(input logic [RAW-1:0] idx);
        logic [NREG-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Opcode class decoders.
    function automatic logic is_rtype(input logic [OPW-1:0] op);
        return (op <= OPW'(8));
    endfunction

    function automatic logic is_imm(input logic [OPW-1:0] op);
        return (op >= OPW'(9)) && (op <= OPW'(11));
    endfunction

    function automatic logic is_muldiv(input logic [OPW-1:0] op);
        return (op == OPW'(12)) || (op == OPW'(13));
    endfunction

    function automatic logic is_unary(input logic [OPW-1:0] op);
        return (op == OPW'(14)) || (op == OPW'(15));
    endfunction

    function automatic logic is_illegal(input logic [OPW-1:0] op);
        return (op >= OPW'(16));
    endfunction

    assign opcode_s = bus.ir[31 -: OPW];
    assign ra_s     = bus.ir[26 -: RAW];
    assign rb_s     = bus.ir[22 -: RAW];
    assign rc_s     = bus.ir[18 -: RAW];

    // State and illegal-flag registers.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r   <= IDLE;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= next_s;
            illegal_r <= illegal_next_s;
        end
    end

    // Next-state logic; the illegal flag is captured on the T3 bail-out and
    // dropped again when FIN retires.
    always_comb begin
        next_s         = state_r;
        illegal_next_s = illegal_r;
        case (state_r)
            IDLE: begin
                if (bus.start) next_s = T0;
                else           next_s = IDLE;
            end
            T0: next_s = T1;
            T1: begin
                if (bus.mem_ready) next_s = T2;
                else               next_s = T1;
            end
            T2: next_s = T3;
            T3: begin
                if (is_illegal(opcode_s)) begin
                    next_s         = FIN;
                    illegal_next_s = 1'b1;
                end else begin
                    next_s = T4;
                end
            end
            T4: next_s = T5;
            T5: begin
                if (is_muldiv(opcode_s)) next_s = T6;
                else                     next_s = FIN;
            end
            T6: next_s = FIN;
            FIN: begin
                // start is not looked at here; a new request must arrive in IDLE
                next_s         = IDLE;
                illegal_next_s = 1'b0;
            end
            default: begin
                next_s         = IDLE;
                illegal_next_s = 1'b0;
            end
        endcase
    end

    // Moore output decode from state and ir.
    always_comb begin
        bus.reg_out   = '0;
        bus.reg_in    = '0;
        bus.HIout     = 1'b0;
        bus.LOout     = 1'b0;
        bus.Zhighout  = 1'b0;
        bus.Zlowout   = 1'b0;
        bus.PCout     = 1'b0;
        bus.MDRout    = 1'b0;
        bus.InPortout = 1'b0;   // reserved input port, never driven onto the bus here
        bus.Cout      = 1'b0;
        bus.PCin      = 1'b0;
        bus.IncPC     = 1'b0;
        bus.MARin     = 1'b0;
        bus.MDRin     = 1'b0;
        bus.Read      = 1'b0;
        bus.IRin      = 1'b0;
        bus.Yin       = 1'b0;
        bus.Zin       = 1'b0;
        bus.HIin      = 1'b0;
        bus.LOin      = 1'b0;
        bus.alu_op    = 5'd0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.illegal   = 1'b0;
        case (state_r)
            IDLE: begin
                bus.busy = 1'b0;
            end
            T0: begin
                bus.busy  = 1'b1;
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
            end
            T1: begin
                // held every cycle while memory stalls
                bus.busy    = 1'b1;
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
            end
            T2: begin
                bus.busy   = 1'b1;
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            T3: begin
                bus.busy = 1'b1;
                // binary/immediate forms latch rb into Y; unary and illegal idle
                if (is_rtype(opcode_s) || is_imm(opcode_s) || is_muldiv(opcode_s)) begin
                    bus.reg_out = reg_onehot(rb_s);
                    bus.Yin     = 1'b1;
                end else begin
                    bus.Yin     = 1'b0;
                end
            end
            T4: begin
                bus.busy   = 1'b1;
                bus.Zin    = 1'b1;
                bus.alu_op = 5'(opcode_s);
                if (is_imm(opcode_s)) begin
                    bus.Cout    = 1'b1;
                end else if (is_unary(opcode_s)) begin
                    bus.reg_out = reg_onehot(rb_s);
                end else begin
                    bus.reg_out = reg_onehot(rc_s);
                end
            end
            T5: begin
                bus.busy    = 1'b1;
                bus.Zlowout = 1'b1;
                if (is_muldiv(opcode_s)) begin
                    bus.LOin   = 1'b1;
                end else begin
                    bus.reg_in = reg_onehot(ra_s);
                end
            end
            T6: begin
                bus.busy     = 1'b1;
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
            end
            FIN: begin
                bus.done    = 1'b1;
                bus.illegal = illegal_r;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bus_sequencer
// Self-checking bench for bus_sequencer. Expected per-cycle output vectors are
// built from the instruction-class rules as a plain list of steps, then
// compared cycle by cycle against the design.
// -----------------------------------------------------------------------------
module tb_bus_sequencer;

    logic clock = 1'b0;
    logic clear;

    bus_sequencer_if bus ();

    bus_sequencer #(.OPW(5), .RAW(4)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // src: HIout LOout Zhighout Zlowout PCout MDRout InPortout Cout
    localparam int S_HI = 7, S_LO = 6, S_ZH = 5, S_ZL = 4, S_PC = 3, S_MDR = 2, S_INP = 1, S_C = 0;
    // ctl: PCin IncPC MARin MDRin Read IRin Yin Zin HIin LOin
    localparam int C_PCIN = 9, C_INC = 8, C_MAR = 7, C_MDR = 6, C_READ = 5, C_IR = 4,
                   C_Y = 3, C_Z = 2, C_HI = 1, C_LO = 0;

    typedef struct packed {
        logic [15:0] reg_out;
        logic [15:0] reg_in;
        logic [7:0]  src;
        logic [9:0]  ctl;
        logic [4:0]  alu_op;
        logic        busy;
        logic        done;
        logic        illegal;
    } vec_t;

    vec_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    function automatic vec_t observe();
        vec_t v;
        v.reg_out = bus.reg_out;
        v.reg_in  = bus.reg_in;
        v.src     = {bus.HIout, bus.LOout, bus.Zhighout, bus.Zlowout,
                     bus.PCout, bus.MDRout, bus.InPortout, bus.Cout};
        v.ctl     = {bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.Read,
                     bus.IRin, bus.Yin, bus.Zin, bus.HIin, bus.LOin};
        v.alu_op  = bus.alu_op;
        v.busy    = bus.busy;
        v.done    = bus.done;
        v.illegal = bus.illegal;
        return v;
    endfunction

    task automatic check_vec(input string tag, input vec_t o, input vec_t e);
        total_cnt++;
        assert (o === e) pass_cnt++;
        else $error("FAIL %s obs ro=%h ri=%h src=%b ctl=%b op=%h bdi=%b%b%b exp ro=%h ri=%h src=%b ctl=%b op=%h bdi=%b%b%b",
                    tag, o.reg_out, o.reg_in, o.src, o.ctl, o.alu_op, o.busy, o.done, o.illegal,
                    e.reg_out, e.reg_in, e.src, e.ctl, e.alu_op, e.busy, e.done, e.illegal);
    endtask

    task automatic check_int(input string tag, input int o, input int e);
        total_cnt++;
        assert (o === e) pass_cnt++;
        else $error("FAIL %s obs=%0d exp=%0d", tag, o, e);
    endtask

    task automatic check_invariants(input string tag);
        int n_src;
        n_src = $countones({bus.reg_out, bus.HIout, bus.LOout, bus.Zhighout, bus.Zlowout,
                            bus.PCout, bus.MDRout, bus.InPortout, bus.Cout});
        check_int({tag, "_bus_onehot"}, int'(n_src <= 1), 1);
        check_int({tag, "_inport"}, int'(bus.InPortout), 0);
        check_int({tag, "_regin_onehot"}, int'($countones(bus.reg_in) <= 1), 1);
    endtask

    // Expected step list for one instruction, straight from the class rules.
    task automatic build_expected(input logic [31:0] ir, input int stalls);
        vec_t v;
        int   op, ra, rb, rc;
        op = int'(ir[31:27]);
        ra = int'(ir[26:23]);
        rb = int'(ir[22:19]);
        rc = int'(ir[18:15]);
        exp_q.delete();
        v = '0; v.busy = 1'b1;
        v.src[S_PC] = 1'b1; v.ctl[C_MAR] = 1'b1; v.ctl[C_INC] = 1'b1; v.ctl[C_Z] = 1'b1;
        exp_q.push_back(v);
        for (int s = 0; s <= stalls; s++) begin
            v = '0; v.busy = 1'b1;
            v.src[S_ZL] = 1'b1; v.ctl[C_PCIN] = 1'b1; v.ctl[C_READ] = 1'b1; v.ctl[C_MDR] = 1'b1;
            exp_q.push_back(v);
        end
        v = '0; v.busy = 1'b1; v.src[S_MDR] = 1'b1; v.ctl[C_IR] = 1'b1;
        exp_q.push_back(v);
        if (op >= 16) begin
            v = '0; v.busy = 1'b1;                       // T3 of an illegal opcode
            exp_q.push_back(v);
            v = '0; v.done = 1'b1; v.illegal = 1'b1;
            exp_q.push_back(v);
        end else begin
            v = '0; v.busy = 1'b1;
            if (op < 14) begin
                v.reg_out = 16'(1) << rb; v.ctl[C_Y] = 1'b1;
            end
            exp_q.push_back(v);
            v = '0; v.busy = 1'b1; v.ctl[C_Z] = 1'b1; v.alu_op = 5'(op);
            if (op >= 9 && op <= 11)  v.src[S_C] = 1'b1;
            else if (op >= 14)        v.reg_out = 16'(1) << rb;
            else                      v.reg_out = 16'(1) << rc;
            exp_q.push_back(v);
            v = '0; v.busy = 1'b1; v.src[S_ZL] = 1'b1;
            if (op == 12 || op == 13) v.ctl[C_LO] = 1'b1;
            else                      v.reg_in = 16'(1) << ra;
            exp_q.push_back(v);
            if (op == 12 || op == 13) begin
                v = '0; v.busy = 1'b1; v.src[S_ZH] = 1'b1; v.ctl[C_HI] = 1'b1;
                exp_q.push_back(v);
            end
            v = '0; v.done = 1'b1;
            exp_q.push_back(v);
        end
        v = '0;                                          // back in IDLE
        exp_q.push_back(v);
    endtask

    // Runs one instruction from IDLE; called at a falling edge.
    task automatic run_instr(input logic [31:0] ir, input int stalls,
                             input bit start_in_fin, input string tag);
        vec_t o, e;
        int   stall_left, done_at, exp_clk, op;
        stall_left = stalls;
        done_at    = -1;
        op         = int'(ir[31:27]);
        build_expected(ir, stalls);
        bus.ir    = ir;
        bus.start = 1'b1;
        @(posedge clock);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clock);
            bus.start = 1'b0;
            o = observe();
            e = exp_q[i];
            check_vec($sformatf("%s_clk%0d", tag, i + 1), o, e);
            check_invariants(tag);
            if (o.done === 1'b1 && done_at < 0) done_at = i + 1;
            if (e.ctl[C_READ]) begin
                if (stall_left > 0) begin
                    bus.mem_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.mem_ready = 1'b1;
                end
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
            if (e.done && start_in_fin) bus.start = 1'b1;
        end
        if (op >= 16)                  exp_clk = 5 + stalls;
        else if (op == 12 || op == 13) exp_clk = 8 + stalls;
        else                           exp_clk = 7 + stalls;
        check_int({tag, "_done_clock"}, done_at, exp_clk);
        bus.start = 1'b0;
    endtask

    initial begin
        logic [31:0] rnd;
        logic [31:0] ir;
        logic [4:0]  op;
        vec_t        o;

        // Reset held for two cycles: everything quiet.
        clear         = 1'b1;
        bus.start     = 1'b0;
        bus.ir        = 32'd0;
        bus.mem_ready = 1'b1;
        @(negedge clock);
        check_vec("reset_c1", observe(), '0);
        @(negedge clock);
        check_vec("reset_c2", observe(), '0);
        clear = 1'b0;
        @(negedge clock);
        check_vec("idle_after_reset", observe(), '0);

        // Directed instructions.
        run_instr(32'h01A3_0000, 0, 1'b0, "add");
        run_instr({5'b01101, 4'd1, 4'd2, 4'd5, 15'h0abc}, 0, 1'b0, "mul");
        run_instr({5'b01001, 4'd1, 4'd2, 4'd0, 15'h1234}, 0, 1'b0, "addi");
        run_instr(32'h01A3_0000, 3, 1'b0, "add_stall3");
        run_instr({5'b10101, 4'd3, 4'd4, 4'd6, 15'h0000}, 0, 1'b1, "illegal");
        run_instr({5'b01110, 4'd7, 4'd7, 4'd7, 15'h0000}, 0, 1'b0, "neg_same_regs");

        // Clear asserted in the middle of T4 of an add.
        bus.ir        = 32'h01A3_0000;
        bus.mem_ready = 1'b1;
        bus.start     = 1'b1;
        @(posedge clock);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            bus.start = 1'b0;
        end
        o = observe();
        check_int("abort_in_t4_alu", int'(o.reg_out), 32'h0040);
        #1 clear = 1'b1;
        #1 check_vec("abort_immediate", observe(), '0);
        @(negedge clock);
        check_vec("abort_hold_c1", observe(), '0);
        @(negedge clock);
        check_vec("abort_hold_c2", observe(), '0);
        clear = 1'b0;
        @(negedge clock);
        check_vec("abort_idle", observe(), '0);
        run_instr(32'h01A3_0000, 0, 1'b0, "add_after_abort");

        // Randomized instructions across all opcode classes.
        for (int n = 0; n < 40; n++) begin
            rnd = $urandom();
            op  = 5'($urandom_range(0, 31));
            ir  = {op, rnd[26:0]};
            run_instr(ir, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      $sformatf("rnd%0d_op%0d", n, op));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bus_sequencer.md
Name: bus_sequencer

Overview:
- Multi-cycle control-step sequencer for the single shared 32-bit datapath bus.
- Sequences one instruction through fetch (T0-T2) and execute (T3-T6).
- Drives the one-hot source enables consumed by the bus mux, the register/latch load enables and the ALU op code.
- Sits between the testbench/top-level start strobe and the datapath; memory is modelled by a Read/mem_ready handshake.

Parameters:
- OPW, 5, opcode width (ir[31:27]).
- RAW, 4, register-field width.

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to execute one instruction; sampled only in IDLE.
- ir  in  32  instruction register contents, valid from T3; ra=ir[26:23], rb=ir[22:19], rc=ir[18:15].
- mem_ready  in  1  memory read complete.
- reg_out  out  16  one-hot Rn out enables (bit n = Rnout).
- reg_in  out  16  one-hot Rn load enables.
- HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout  out  1 each  remaining bus source enables.
- PCin, IncPC, MARin, MDRin, Read, IRin, Yin, Zin, HIin, LOin  out  1 each  load and control strobes.
- alu_op  out  5  ALU operation; equals ir[31:27] in T4, 0 otherwise.
- busy  out  1  high from T0 through T6.
- done  out  1  one-cycle pulse after the last step.
- illegal  out  1  one-cycle pulse, with done, for an unsupported opcode.

Behaviour:
- Reset: async clear forces state IDLE and every output to 0. Clear mid-instruction aborts immediately, with no further strobes.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, FIN. All outputs are decoded combinationally from the registered state and ir (Moore).
- IDLE -> T0 on start. Otherwise stay.
- T0: PCout, MARin, IncPC, Zin. Next state T1.
- T1: Zlowout, PCin, Read, MDRin. Stays in T1 while mem_ready=0, with strobes held every cycle; advances on mem_ready=1.
- T2: MDRout, IRin. Next state T3.
- Opcode classes:
  - R-type ALU 00000-01000 (add, sub, and, or, shr, shra, shl, ror, rol).
  - Immediate 01001-01011 (addi, andi, ori).
  - div 01100, mul 01101.
  - Unary 01110-01111 (neg, not).
  - 10000-11111 are illegal.
- T3:
  - Binary and immediate: reg_out[rb], Yin.
  - Unary: no outputs.
  - Illegal: go to FIN with illegal=1.
- T4:
  - R-type: reg_out[rc], Zin.
  - Immediate: Cout, Zin.
  - mul/div: reg_out[rc], Zin.
  - Unary: reg_out[rb], Zin.
  - alu_op = opcode in all cases.
- T5:
  - mul/div: Zlowout, LOin.
  - Others: Zlowout, reg_in[ra].
- T6 (mul/div only): Zhighout, HIin. All other classes skip T6.
- FIN: done=1 (and illegal=1 if flagged), then IDLE. start in FIN is ignored.
- Invariants checked by assertion:
  - At most one bus source enable (reg_out bits, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout) is high in any cycle.
  - InPortout is never asserted by this block (reserved).
  - reg_in has at most one bit set.
- Cycle count from start to done, with mem_ready tied high: 7 clocks for non-mul/div, 8 for mul/div. Each mem_ready stall cycle adds 1.
- ra=rb=rc is legal, with no special handling.

Test Plan:
- Reset: clear=1 for 2 cycles, also asserted mid-T4 of a running add. Required: all outputs 0 and state IDLE within the same cycle; next start runs from T0.
- add, ir=0x01A30000 (ra=3, rb=4, rc=6), mem_ready=1. Required sequence:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
  - T3: reg_out=0x0010, Yin.
  - T4: reg_out=0x0040, Zin, alu_op=0.
  - T5: Zlowout, reg_in=0x0008.
  - FIN: done; 7 clocks total.
- mul, opcode 01101, rb=2, rc=5. Required: T5 Zlowout+LOin, T6 Zhighout+HIin, no reg_in; done at clock 8.
- addi, opcode 01001, ra=1, rb=2. Required: T4 has Cout=1, Zin=1, reg_out=0; T5 reg_in=0x0002.
- mem_ready held low 3 cycles in T1. Required: T1 strobes held 4 cycles total, then T2; done at clock 10. Bus one-hot assertion never fires across all tests.
- Illegal opcode 10101. Required: done=1 and illegal=1 together at clock 5; no reg_in, HIin or LOin ever asserted; start pulsed during FIN is ignored.
